radio86_bus_arbiter: RTL

Sits between the KR580VM80A core and the shared memory/peripheral bus of the Radio-86 board. Generates the CPU clock-enable and decodes the CPU address into RAM, ROM and four I/O selects. Returns read data to the CPU. Interleaves short video-DMA bursts from the CRT/DMA path, freezing the CPU (cpu_ce low) while they run.

---
 rtl/radio86_pkg.sv | 23 ++
 rtl/radio86_bus_arbiter_if.sv | 36 +++
 rtl/radio86_addr_decode.sv | 25 ++
 rtl/radio86_bus_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/radio86_pkg.sv
// Shared constants for the Radio-86 bus arbiter: address map, I/O select
// indices and the arbiter state encoding.
package radio86_pkg;

  localparam logic [15:0] RAM_TOP      = 16'h7FFF;
  localparam logic [15:0] PPI1_BASE    = 16'h8000;
  localparam logic [15:0] PPI2_BASE    = 16'hA000;
  localparam logic [15:0] CRT_BASE     = 16'hC000;
  localparam logic [15:0] DMAC_BASE    = 16'hE000;
  localparam logic [15:0] ROM_BASE_DEF = 16'hF800;

  localparam int IO_PPI1 = 0;
  localparam int IO_PPI2 = 1;
  localparam int IO_CRT  = 2;
  localparam int IO_DMAC = 3;

  typedef enum logic [1:0] {
    C_SLOT,
    D_ADDR,
    D_DATA
  } arb_state_e;

endpackage

// File: rtl/radio86_bus_arbiter_if.sv
// CPU / memory / I/O / video-DMA signal bundle around the bus arbiter.
// master = the arbiter itself, slave = CPU core, memories and DMA requester.
interface radio86_bus_arbiter_if;

  logic        cpu_ce;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [3:0]  io_cs;
  logic        io_we;
  logic [7:0]  io_rdata;
  logic        dma_req;
  logic [15:0] dma_address;
  logic        dma_ack;
  logic [7:0]  dma_data;

  modport master (
    output cpu_ce, cpu_in, mem_address, mem_wdata, mem_we, io_cs, io_we,
           dma_ack, dma_data,
    input  cpu_address, cpu_out, cpu_we, mem_rdata, io_rdata, dma_req,
           dma_address
  );

  modport slave (
    input  cpu_ce, cpu_in, mem_address, mem_wdata, mem_we, io_cs, io_we,
           dma_ack, dma_data,
    output cpu_address, cpu_out, cpu_we, mem_rdata, io_rdata, dma_req,
           dma_address
  );

endinterface

// File: rtl/radio86_addr_decode.sv
// Combinational Radio-86 address decoder: RAM, ROM and the four one-hot I/O
// selects. Shared by the arbiter and the memory-side glue.
module radio86_addr_decode
  import radio86_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEF
) (
  input  logic [15:0] i_addr,
  output logic        o_is_ram,
  output logic        o_is_rom,
  output logic [3:0]  o_io_cs
);

  always_comb begin
    o_io_cs          = '0;
    o_is_ram         = (i_addr <= RAM_TOP);
    o_is_rom         = (i_addr >= ROM_BASE);
    o_io_cs[IO_PPI1] = (i_addr >= PPI1_BASE) && (i_addr < PPI2_BASE);
    o_io_cs[IO_PPI2] = (i_addr >= PPI2_BASE) && (i_addr < CRT_BASE);
    o_io_cs[IO_CRT]  = (i_addr >= CRT_BASE)  && (i_addr < DMAC_BASE);
    // DMAC ends where ROM starts so a moved ROM never double-selects.
    o_io_cs[IO_DMAC] = (i_addr >= DMAC_BASE) && (i_addr < ROM_BASE);
  end

endmodule

// File: rtl/radio86_bus_arbiter.sv
// Radio-86 CPU/video-DMA bus arbiter: CPU slots of CPU_DIV clocks, each
// optionally followed by up to BURST two-clock DMA words.
//   state  | meaning
//   C_SLOT | CPU owns the bus, cpu_ce pulses on the last clock of the slot
//   D_ADDR | DMA address on the memory bus, CPU frozen
//   D_DATA | DMA word captured, ack issued next clock
module radio86_bus_arbiter
  import radio86_pkg::*;
#(
  parameter int          CPU_DIV  = 4,
  parameter int          BURST    = 4,
  parameter logic [15:0] ROM_BASE = 16'hF800
) (
  input  logic                  clock,
  input  logic                  reset,
  radio86_bus_arbiter_if.master bus
);

  localparam logic [3:0] DIV_LAST  = 4'(CPU_DIV - 1);
  localparam logic [4:0] BURST_LIM = 5'(BURST);

  arb_state_e r_state, w_state_nxt;
  logic [3:0] r_div_cnt, w_div_nxt;
  logic [3:0] r_burst_cnt, w_burst_nxt;
  logic [4:0] w_burst_inc;
  logic       r_armed;
  logic       r_dma_ack, w_dma_capture;
  logic [7:0] r_dma_data;
  logic       w_is_ram, w_is_rom;
  logic [3:0] w_io_cs;

  radio86_addr_decode #(.ROM_BASE(ROM_BASE)) u_decode (
    .i_addr   (bus.cpu_address),
    .o_is_ram (w_is_ram),
    .o_is_rom (w_is_rom),
    .o_io_cs  (w_io_cs)
  );

  // r_armed blocks write strobes during the first clock after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= C_SLOT;
      r_div_cnt   <= '0;
      r_burst_cnt <= '0;
      r_armed     <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_dma_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_cnt   <= w_div_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_armed     <= 1'b1;
      r_dma_ack   <= w_dma_capture;
      if (w_dma_capture) r_dma_data <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div_cnt;
    w_burst_nxt     = r_burst_cnt;
    w_burst_inc     = {1'b0, r_burst_cnt} + 5'd1;
    w_dma_capture   = 1'b0;
    bus.cpu_ce      = 1'b0;
    bus.cpu_in      = '0;
    bus.mem_address = bus.cpu_address;
    bus.mem_wdata   = '0;
    bus.mem_we      = 1'b0;
    bus.io_cs       = '0;
    bus.io_we       = 1'b0;
    case (r_state)
      C_SLOT: begin
        bus.io_cs  = w_io_cs;
        bus.cpu_in = (w_is_ram || w_is_rom) ? bus.mem_rdata : bus.io_rdata;
        if (r_div_cnt == 4'd0 && r_armed) begin
          bus.mem_we    = bus.cpu_we & w_is_ram;
          bus.io_we     = bus.cpu_we & (|w_io_cs);
          bus.mem_wdata = bus.cpu_out;
        end
        if (r_div_cnt == DIV_LAST) begin
          bus.cpu_ce  = 1'b1;
          w_div_nxt   = '0;
          w_burst_nxt = '0;
          w_state_nxt = bus.dma_req ? D_ADDR : C_SLOT;
        end else begin
          w_div_nxt = r_div_cnt + 4'd1;
        end
      end
      D_ADDR: begin
        bus.mem_address = bus.dma_address;
        w_state_nxt     = D_DATA;
      end
      D_DATA: begin
        bus.mem_address = bus.dma_address;
        w_dma_capture   = 1'b1;
        w_burst_nxt     = w_burst_inc[3:0];
        w_state_nxt     = (bus.dma_req && (w_burst_inc < BURST_LIM)) ? D_ADDR : C_SLOT;
      end
      default: w_state_nxt = C_SLOT;
    endcase
    // Registers already sit at their reset values; only decode-driven outputs need forcing.
    if (reset) begin
      bus.io_cs  = '0;
      bus.cpu_in = '0;
    end
  end

  assign bus.dma_ack  = r_dma_ack;
  assign bus.dma_data = r_dma_data;

endmodule
